// File: rtl/dijkstra_pkg.sv
// Shared sizing defaults and FSM state encoding for the Dijkstra path unwinder.
package dijkstra_pkg;

  localparam int NODE_W   = 6;
  localparam int MAX_PATH = 64;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    READ,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/dijkstra_path_lifo.sv
// Path LIFO: push/pop with stack pointer and combinational top-of-stack read.
// Storage is never cleared; only sp is reset, so stale entries are unreachable.
module dijkstra_path_lifo #(
  parameter int NODE_W   = 6,
  parameter int MAX_PATH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            push,
  input  logic                            pop,
  input  logic [NODE_W-1:0]               din,
  output logic [$clog2(MAX_PATH+1)-1:0]   sp,
  output logic [NODE_W-1:0]               top
);

  localparam int SP_W  = $clog2(MAX_PATH + 1);
  localparam int IDX_W = (MAX_PATH > 1) ? $clog2(MAX_PATH) : 1;

  logic [NODE_W-1:0] mem [MAX_PATH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;

  assign wr_idx  = IDX_W'(sp);
  assign top_idx = IDX_W'(sp - 1'b1);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + 1'b1;
    end else if (pop && (sp != '0)) begin
      sp <= sp - 1'b1;
    end
  end

  // Guard the empty case so top never indexes past the array.
  assign top = (sp == SP_W'(0)) ? '0 : mem[top_idx];

endmodule

// File: rtl/dijkstra_path_unwind.sv
// Walks the predecessor table from dst back to src, stacking nodes for forward readout.
// DONE is reached 2L cycles after start for an L-node path; rd_pop pops one node per strobe.
module dijkstra_path_unwind
  import dijkstra_pkg::state_t, dijkstra_pkg::IDLE, dijkstra_pkg::PUSH,
         dijkstra_pkg::READ, dijkstra_pkg::DONE, dijkstra_pkg::ERR;
#(
  parameter int NODE_W   = dijkstra_pkg::NODE_W,
  parameter int MAX_PATH = dijkstra_pkg::MAX_PATH
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            start,
  input  logic [NODE_W-1:0]               src_node,
  input  logic [NODE_W-1:0]               dst_node,
  output logic [NODE_W-1:0]               pred_addr,
  input  logic [NODE_W-1:0]               pred_data,
  input  logic                            pred_valid,
  input  logic                            rd_pop,
  output logic [NODE_W-1:0]               path_node,
  output logic [$clog2(MAX_PATH+1)-1:0]   path_count,
  output logic                            busy,
  output logic                            ready,
  output logic                            err
);

  localparam int CNT_W = $clog2(MAX_PATH + 1);

  state_t            state;
  logic [NODE_W-1:0] cur;
  logic [NODE_W-1:0] src_q;
  logic [CNT_W-1:0]  sp;
  logic [NODE_W-1:0] top;
  logic              can_start;
  logic              do_start;
  logic              do_push;
  logic              do_pop;

  assign can_start = (state == IDLE) || (state == DONE) || (state == ERR);
  assign do_start  = start && can_start;
  assign do_push   = (state == PUSH);
  // A new walk takes priority over a pop arriving in the same cycle.
  assign do_pop    = (state == DONE) && rd_pop && !start;

  dijkstra_path_lifo #(
    .NODE_W   (NODE_W),
    .MAX_PATH (MAX_PATH)
  ) u_lifo (
    .clk  (ACLK),
    .rst  (ARESET),
    .clr  (do_start),
    .push (do_push),
    .pop  (do_pop),
    .din  (cur),
    .sp   (sp),
    .top  (top)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
      cur   <= '0;
      src_q <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            src_q <= src_node;
            cur   <= dst_node;
            state <= PUSH;
            busy  <= 1'b1;
            ready <= 1'b0;
            err   <= 1'b0;
          end else if (do_pop && (sp == CNT_W'(1))) begin
            state <= IDLE;
            ready <= 1'b0;
          end
        end
        PUSH: begin
          // Reaching src wins over a full stack: a MAX_PATH-node path still fits.
          if (cur == src_q) begin
            state <= DONE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else if (sp == CNT_W'(MAX_PATH - 1)) begin
            state <= ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          if (!pred_valid) begin
            state <= ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            cur   <= pred_data;
            state <= PUSH;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

  assign pred_addr  = cur;
  assign path_count = ready ? sp  : '0;
  assign path_node  = ready ? top : '0;

endmodule

// File: tb/tb_dijkstra_path_unwind.sv
// Directed bench: table of walks on a 64-entry DUT plus hand sequences and a MAX_PATH=4 instance.
module tb_dijkstra_path_unwind;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_m, rd_pop_m, start_o, rd_pop_o;
  logic [5:0] src_m, dst_m, src_o, dst_o;
  logic [5:0] pa_m, pd_m, pa_o, pd_o, node_m, node_o;
  logic       pv_m, pv_o;
  logic [6:0] cnt_m;
  logic [2:0] cnt_o;
  logic       busy_m, ready_m, err_m, busy_o, ready_o, err_o;

  dijkstra_path_unwind u_dut (
    .ACLK(clk), .ARESET(rst), .start(start_m), .src_node(src_m), .dst_node(dst_m),
    .pred_addr(pa_m), .pred_data(pd_m), .pred_valid(pv_m), .rd_pop(rd_pop_m),
    .path_node(node_m), .path_count(cnt_m), .busy(busy_m), .ready(ready_m), .err(err_m)
  );

  dijkstra_path_unwind #(.NODE_W(6), .MAX_PATH(4)) u_ovf (
    .ACLK(clk), .ARESET(rst), .start(start_o), .src_node(src_o), .dst_node(dst_o),
    .pred_addr(pa_o), .pred_data(pd_o), .pred_valid(pv_o), .rd_pop(rd_pop_o),
    .path_node(node_o), .path_count(cnt_o), .busy(busy_o), .ready(ready_o), .err(err_o)
  );

  logic [5:0] pred_tab [64];
  logic       pred_ok  [64];

  always @(posedge clk) begin
    pd_m <= pred_tab[pa_m];
    pv_m <= pred_ok[pa_m];
    pd_o <= pred_tab[pa_o];
    pv_o <= pred_ok[pa_o];
  end

  typedef struct {
    logic [5:0]       src;
    logic [5:0]       dst;
    int               cyc;
    bit               is_err;
    int               len;
    logic [9:0][5:0]  nodes;
  } vec_t;

  vec_t vecs [5];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic walk(input logic [5:0] s, input logic [5:0] d, output int n);
    src_m = s; dst_m = d; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    n = 1;
    chk("busy_after_start", int'(busy_m), 1);
    chk("err_clear_after_start", int'(err_m), 0);
    while (!(ready_m || err_m) && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pop_m();
    rd_pop_m = 1'b1;
    @(negedge clk);
    rd_pop_m = 1'b0;
  endtask

  task automatic run_vec(input int k);
    int n;
    walk(vecs[k].src, vecs[k].dst, n);
    chk($sformatf("v%0d_cycles", k), n, vecs[k].cyc);
    if (vecs[k].is_err) begin
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_err_hold", k), int'(err_m), 1);
      chk($sformatf("v%0d_err_ready", k), int'(ready_m), 0);
      chk($sformatf("v%0d_err_busy", k), int'(busy_m), 0);
      chk($sformatf("v%0d_err_count", k), int'(cnt_m), 0);
      chk($sformatf("v%0d_err_node", k), int'(node_m), 0);
    end else begin
      for (int i = 0; i < vecs[k].len; i++) begin
        chk($sformatf("v%0d_ready_%0d", k, i), int'(ready_m), 1);
        chk($sformatf("v%0d_node_%0d", k, i), int'(node_m), int'(vecs[k].nodes[i]));
        chk($sformatf("v%0d_count_%0d", k, i), int'(cnt_m), vecs[k].len - i);
        pop_m();
      end
      chk($sformatf("v%0d_idle_ready", k), int'(ready_m), 0);
      chk($sformatf("v%0d_idle_count", k), int'(cnt_m), 0);
      chk($sformatf("v%0d_idle_node", k), int'(node_m), 0);
      pop_m();
      chk($sformatf("v%0d_extra_pop_count", k), int'(cnt_m), 0);
      chk($sformatf("v%0d_extra_pop_ready", k), int'(ready_m), 0);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin
      pred_tab[i] = 6'd0;
      pred_ok[i]  = 1'b0;
    end
    pred_tab[7] = 6'd5;  pred_ok[7] = 1'b1;
    pred_tab[5] = 6'd3;  pred_ok[5] = 1'b1;
    pred_tab[12] = 6'd1; pred_ok[12] = 1'b1;
    for (int i = 41; i <= 49; i++) begin
      pred_tab[i] = 6'(i - 1);
      pred_ok[i]  = 1'b1;
    end
    for (int i = 21; i <= 24; i++) begin
      pred_tab[i] = 6'(i - 1);
      pred_ok[i]  = 1'b1;
    end

    vecs[0] = '{src: 6'd3,  dst: 6'd7,  cyc: 6,  is_err: 1'b0, len: 3,  nodes: '0};
    vecs[0].nodes[0] = 6'd3; vecs[0].nodes[1] = 6'd5; vecs[0].nodes[2] = 6'd7;
    vecs[1] = '{src: 6'd12, dst: 6'd12, cyc: 2,  is_err: 1'b0, len: 1,  nodes: '0};
    vecs[1].nodes[0] = 6'd12;
    vecs[2] = '{src: 6'd0,  dst: 6'd9,  cyc: 3,  is_err: 1'b1, len: 0,  nodes: '0};
    vecs[3] = '{src: 6'd40, dst: 6'd49, cyc: 20, is_err: 1'b0, len: 10, nodes: '0};
    for (int i = 0; i < 10; i++) vecs[3].nodes[i] = 6'(40 + i);
    vecs[4] = '{src: 6'd5,  dst: 6'd7,  cyc: 4,  is_err: 1'b0, len: 2,  nodes: '0};
    vecs[4].nodes[0] = 6'd5; vecs[4].nodes[1] = 6'd7;

    rst = 1'b1;
    start_m = 1'b0; rd_pop_m = 1'b0; src_m = '0; dst_m = '0;
    start_o = 1'b0; rd_pop_o = 1'b0; src_o = '0; dst_o = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_m), 0);
    chk("rst_ready", int'(ready_m), 0);
    chk("rst_err", int'(err_m), 0);
    chk("rst_count", int'(cnt_m), 0);
    chk("rst_node", int'(node_m), 0);
    chk("rst_pred_addr", int'(pa_m), 0);
    rst = 1'b0;
    @(negedge clk);

    pop_m();
    chk("idle_pop_ready", int'(ready_m), 0);
    chk("idle_pop_count", int'(cnt_m), 0);
    chk("idle_pop_busy", int'(busy_m), 0);

    for (int k = 0; k < 5; k++) run_vec(k);

    // Start and pop together in DONE: the new walk wins.
    walk(6'd3, 6'd7, n);
    chk("sim_first_ready", int'(ready_m), 1);
    src_m = 6'd12; dst_m = 6'd12; start_m = 1'b1; rd_pop_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0; rd_pop_m = 1'b0;
    chk("sim_busy", int'(busy_m), 1);
    chk("sim_ready_low", int'(ready_m), 0);
    @(negedge clk);
    chk("sim_ready", int'(ready_m), 1);
    chk("sim_node", int'(node_m), 12);
    chk("sim_count", int'(cnt_m), 1);
    pop_m();
    chk("sim_idle", int'(ready_m), 0);

    // Start during a walk is ignored.
    src_m = 6'd40; dst_m = 6'd49; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    n = 1;
    while (!(ready_m || err_m) && n < 200) begin
      if (n == 3) begin
        src_m = 6'd3; dst_m = 6'd7; start_m = 1'b1;
      end
      @(negedge clk);
      start_m = 1'b0;
      n++;
    end
    chk("ign_cycles", n, 20);
    chk("ign_node", int'(node_m), 40);
    chk("ign_count", int'(cnt_m), 10);

    // Reset in READ of the 10-node walk, then redo it.
    src_m = 6'd40; dst_m = 6'd49; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", int'(busy_m), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy_m), 0);
    chk("mid_rst_ready", int'(ready_m), 0);
    chk("mid_rst_err", int'(err_m), 0);
    chk("mid_rst_count", int'(cnt_m), 0);
    chk("mid_rst_node", int'(node_m), 0);
    chk("mid_rst_addr", int'(pa_m), 0);
    run_vec(3);

    // MAX_PATH=4: a 5-node chain overflows, a 4-node chain just fits.
    src_o = 6'd20; dst_o = 6'd24; start_o = 1'b1;
    @(negedge clk);
    start_o = 1'b0;
    n = 1;
    chk("ovf_busy", int'(busy_o), 1);
    while (!(ready_o || err_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_cycles", n, 8);
    chk("ovf_err", int'(err_o), 1);
    chk("ovf_ready", int'(ready_o), 0);
    chk("ovf_count", int'(cnt_o), 0);

    src_o = 6'd21; dst_o = 6'd24; start_o = 1'b1;
    @(negedge clk);
    start_o = 1'b0;
    n = 1;
    chk("fit_err_clear", int'(err_o), 0);
    while (!(ready_o || err_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fit_cycles", n, 8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fit_ready_%0d", i), int'(ready_o), 1);
      chk($sformatf("fit_node_%0d", i), int'(node_o), 21 + i);
      chk($sformatf("fit_count_%0d", i), int'(cnt_o), 4 - i);
      rd_pop_o = 1'b1;
      @(negedge clk);
      rd_pop_o = 1'b0;
    end
    chk("fit_idle", int'(ready_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
